// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock with a start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement truncating division; unsigned otherwise.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  dvd;
  logic [N-1:0]  div;
  logic [N-1:0]  rem;
  logic [N:0]    rem_shift;
  logic [N:0]    rem_diff;
  logic [N:0]    rem_next;
  logic [N-1:0]  dvd_next;
  logic          ge;
  logic          accept;
  logic          last;
  logic          rem_unused;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(1));

  // The shifted partial remainder carries one extra bit so compare/subtract never overflow.
  always_comb begin
    rem_shift = {rem, dvd[N-1]};
    rem_diff  = rem_shift - {1'b0, div};
    ge        = (rem_shift >= {1'b0, div});
    rem_next  = ge ? rem_diff : rem_shift;
    dvd_next  = {dvd[N-2:0], ge};
  end

  assign rem_unused = rem_next[N];

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = a[N-1] ? -a : a;
  assign b_mag = b[N-1] ? -b : b;
  assign q_fix = neg_q ? -dvd_next : dvd_next;
  assign r_fix = neg_r ? -rem_next[N-1:0] : rem_next[N-1:0];

  // Result signs are fixed at acceptance and applied on the final RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && (b != '0)) begin
      neg_q <= a[N-1] ^ b[N-1];
      neg_r <= a[N-1];
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_fix = dvd_next;
  assign r_fix = rem_next[N-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (b != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = (b != '0) ? RUN : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero divisor skips the iteration and publishes the saturated result straight away.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd <= '0;
      div <= '0;
      rem <= '0;
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      if (b != '0) begin
        dvd <= a_mag;
        div <= b_mag;
        rem <= '0;
        cnt <= CW'(N);
      end else begin
        q   <= '1;
        r   <= a;
        dbz <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd <= dvd_next;
      rem <= rem_next[N-1:0];
      cnt <= cnt - CW'(1);
      if (last) begin
        q   <= q_fix;
        r   <= r_fix;
        dbz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake cases plus a shuffled sweep of
// every operand pair, compared against plain-arithmetic division.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dbz;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void refDivide(input logic [N-1:0] x, input logic [N-1:0] y,
                                    output logic [N-1:0] eq, output logic [N-1:0] er,
                                    output logic edbz);
`ifdef SEQ_DIV_SIGNED_EN
    int sx;
    int sy;
`endif
    if (y == '0) begin
      eq   = '1;
      er   = x;
      edbz = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sx = $signed(x);
      sy = $signed(y);
      eq = N'(sx / sy);
      er = N'(sx % sy);
`else
      eq = x / y;
      er = x % y;
`endif
      edbz = 1'b0;
    end
  endfunction

  // Returns in the done cycle (or after the cycle budget) with start released.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y, input bit hold,
                               output int lat, output int busyCycles);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      a = N'(1);
      b = N'(1);
    end else begin
      start = 1'b0;
      a     = N'($urandom);
      b     = N'($urandom);
    end
    lat        = -1;
    busyCycles = 0;
    for (int k = 0; k < N + 4; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busyCycles++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                             input bit hold);
    int           lat;
    int           busyCycles;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         edbz;
    applyStimulus(x, y, hold, lat, busyCycles);
    refDivide(x, y, eq, er, edbz);
    checkOutput({tag, "_lat"}, lat, (y == '0) ? 0 : N);
    checkOutput({tag, "_busy"}, busyCycles, (y == '0) ? 0 : N);
    checkOutput({tag, "_q"}, q, eq);
    checkOutput({tag, "_r"}, r, er);
    checkOutput({tag, "_dbz"}, dbz, edbz);
  endtask

  initial begin
    int order[256];
    int doneSeen;
    int busySeen;
    int j;
    int tmp;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_q", q, 0);
    checkOutput("rst_r", r, 0);
    checkOutput("rst_dbz", dbz, 0);

    // Reset must win over a simultaneous start.
    start = 1'b1;
    a     = N'(3);
    b     = N'(1);
    @(posedge clk);
    #1;
    checkOutput("rstwin_busy", busy, 0);
    checkOutput("rstwin_done", done, 0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    runAndCheck("t1", N'(13), N'(3), 1'b0);
`ifndef SEQ_DIV_SIGNED_EN
    checkOutput("t1_q_const", q, 4);
    checkOutput("t1_r_const", r, 1);
`endif
    @(posedge clk);
    #1;

    runAndCheck("t2", N'(7), N'(0), 1'b0);
    checkOutput("t2_q_const", q, 4'hF);
    checkOutput("t2_r_const", r, 7);
    @(posedge clk);
    #1;

    runAndCheck("t3a", N'(15), N'(1), 1'b0);
    checkOutput("t3a_q_const", q, 15);
    runAndCheck("t3b", N'(2), N'(5), 1'b0);
    checkOutput("t3b_q_const", q, 0);
    checkOutput("t3b_r_const", r, 2);
    @(posedge clk);
    #1;

    runAndCheck("t4", N'(9), N'(2), 1'b1);
`ifndef SEQ_DIV_SIGNED_EN
    checkOutput("t4_q_const", q, 4);
    checkOutput("t4_r_const", r, 1);
`endif
    @(posedge clk);
    #1;

    // Abandon a run with reset in its second cycle.
    a     = N'(5);
    b     = N'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_q", q, 0);
    checkOutput("abort_r", r, 0);
    checkOutput("abort_dbz", dbz, 0);
    doneSeen = 0;
    busySeen = 0;
    for (int k = 0; k < N + 2; k++) begin
      if (done) doneSeen++;
      if (busy) busySeen++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_done", doneSeen, 0);
    checkOutput("abort_busy", busySeen, 0);

`ifdef SEQ_DIV_SIGNED_EN
    runAndCheck("s1", 4'b1001, N'(2), 1'b0);
    checkOutput("s1_q_const", q, 4'b1101);
    checkOutput("s1_r_const", r, 4'b1111);
    runAndCheck("s2", 4'b1000, 4'b1111, 1'b0);
    checkOutput("s2_q_const", q, 4'b1000);
    checkOutput("s2_r_const", r, 0);
    checkOutput("s2_dbz_const", dbz, 0);
    @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      runAndCheck("sweep", N'(order[i] >> 4), N'(order[i] & 15), 1'b0);
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
